// File: rtl/mult_ctrl_pkg.sv
// Shared decode constants, FSM state type and counter width for the multiplier issue controller.
package mult_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mult_cycle_counter.sv
// Loadable down-counter for the multiplier busy window; zero_next flags the last busy cycle.
// Load takes effect on the next edge; no backpressure, dec is only asserted while a count is live.
module mult_cycle_counter
    import mult_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_next
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            // The FSM only decrements while BUSY, where the count is always >= 1.
            assert (count != '0);
            count <= count - 1'b1;
        end
    end

    assign zero_next = (count == CNT_W'(1));

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues MULT/MULTU to the multi-cycle multiplier and stalls dependent MFHI/MFLO or a second multiply
// until HI/LO are valid. Optional stall_count output enabled by `MULT_ISSUE_CTRL_PERF_EN.
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op_code,
    input  logic [5:0]  control_unit_funct,
    input  logic        stall_ext,
    input  logic        flush_d,
    output logic        start_mult,
    output logic        mult_sign,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        mult_busy
`ifdef MULT_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    state_t state, state_nxt;
    logic   is_mul, is_mf, issue, hazard, zero_next;

    assign is_mul = (op_code == OP_RTYPE) &&
                    ((control_unit_funct == FUNCT_MULT) || (control_unit_funct == FUNCT_MULTU));
    assign is_mf  = (op_code == OP_RTYPE) &&
                    ((control_unit_funct == FUNCT_MFHI) || (control_unit_funct == FUNCT_MFLO));

    // Outputs are held low while reset is asserted, so a stalled MFHI is released in the reset cycle.
    assign issue  = !reset && is_mul && !stall_ext && !flush_d && (state == IDLE);
    assign hazard = !reset && (state == BUSY) && (is_mul || is_mf) && !flush_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)     state_nxt = BUSY;
            BUSY:    if (zero_next) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_mult = issue;
        mult_sign  = issue && (control_unit_funct == FUNCT_MULT);
        stall_f    = hazard;
        stall_d    = hazard;
        flush_e    = hazard;
        mult_busy  = (state == BUSY);
    end

    mult_cycle_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (issue),
        .load_val  (CNT_W'(MULT_CYCLES)),
        .dec       (state == BUSY),
        .zero_next (zero_next)
    );

`ifdef MULT_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_d && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed and randomized bench for mult_issue_ctrl against a cycle-indexed busy-window model.
module tb_mult_issue_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       stall_ext;
    logic       flush_d;
    logic       start_mult, mult_sign, stall_f, stall_d, flush_e, mult_busy;
`ifdef MULT_ISSUE_CTRL_PERF_EN
    logic [31:0] stall_count;
`endif

    mult_issue_ctrl #(.MULT_CYCLES(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .op_code            (op_code),
        .control_unit_funct (control_unit_funct),
        .stall_ext          (stall_ext),
        .flush_d            (flush_d),
        .start_mult         (start_mult),
        .mult_sign          (mult_sign),
        .stall_f            (stall_f),
        .stall_d            (stall_d),
        .flush_e            (flush_e),
        .mult_busy          (mult_busy)
`ifdef MULT_ISSUE_CTRL_PERF_EN
        ,
        .stall_count        (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          busy_end = -1;   // last cycle index in which the multiplier is in flight
    logic [31:0] exp_cnt  = 0;
    logic        prev_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic se, input logic fd);
        reset              = rst;
        op_code            = op;
        control_unit_funct = fn;
        stall_ext          = se;
        flush_d            = fd;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic mul, mf, e_busy, e_issue, e_haz;
        @(negedge clk);
        mul     = (op_code == 6'h00) && (control_unit_funct == 6'h18 || control_unit_funct == 6'h19);
        mf      = (op_code == 6'h00) && (control_unit_funct == 6'h10 || control_unit_funct == 6'h12);
        e_busy  = (cyc <= busy_end);
        e_issue = !reset && !e_busy && mul && !stall_ext && !flush_d;
        e_haz   = !reset && e_busy && (mul || mf) && !flush_d;
        chk("start_mult", 32'(start_mult), 32'(e_issue));
        chk("mult_sign",  32'(mult_sign),  32'(e_issue && control_unit_funct == 6'h18));
        chk("stall_f",    32'(stall_f),    32'(e_haz));
        chk("stall_d",    32'(stall_d),    32'(e_haz));
        chk("flush_e",    32'(flush_e),    32'(e_haz));
        chk("mult_busy",  32'(mult_busy),  32'(e_busy));
        chk("start_b2b",  32'(start_mult && prev_start), 32'd0);
`ifdef MULT_ISSUE_CTRL_PERF_EN
        chk("stall_count", stall_count, exp_cnt);
`endif
        prev_start = start_mult;
        @(posedge clk);
        if (reset) begin
            busy_end = -1;
            exp_cnt  = 0;
        end else begin
            if (e_issue) busy_end = cyc + N;
            if (e_haz && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input logic [5:0] fn);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 6'h00, fn, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [5:0] fn, op;
        // Reset with MULT in decode: first edge unchecked, second reset cycle checked.
        drive(1'b1, 6'h00, 6'h18, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        tick();
        // Plain MULT, then idle instructions until it drains.
        run(1, 6'h18);
        run(N + 2, 6'h20);
        // MULTU followed by a dependent MFLO held in decode.
        run(1, 6'h19);
        run(N + 1, 6'h12);
        run(2, 6'h20);
        // Back-to-back MULT.
        run(1, 6'h18);
        run(N + 1, 6'h18);
        run(N + 1, 6'h20);
        // External stall blocks issue for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'h00, 6'h18, 1'b1, 1'b0);
            tick();
        end
        run(1, 6'h18);
        run(N + 1, 6'h20);
        // Killed MULT never issues.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'h00, 6'h18, 1'b0, 1'b1);
            tick();
        end
        run(1, 6'h20);
        // Reset during busy with MFHI stalled, then a fresh MULT+MFHI.
        run(1, 6'h18);
        run(1, 6'h10);
        drive(1'b1, 6'h00, 6'h10, 1'b0, 1'b0);
        tick();
        run(2, 6'h10);
        run(1, 6'h18);
        run(N + 1, 6'h10);
        run(1, 6'h20);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       fn = 6'h18;
                1:       fn = 6'h19;
                2:       fn = 6'h10;
                3:       fn = 6'h12;
                4:       fn = 6'h20;
                default: fn = 6'($urandom_range(0, 63));
            endcase
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
            drive($urandom_range(0, 99) == 0, op, fn,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
